// File: rtl/shift_reg_pkg.sv
// Mode encoding and next-state function for the universal shift register.
// next_q works on a MAX_W-bit container, so WIDTH must not exceed MAX_W.
package shift_reg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_CLR  = 3'b110,
      MODE_RSVD = 3'b111
   } mode_t;

   localparam int unsigned MAX_W = 64;

   // Operates on the low w bits; bits above w in the result are always zero.
   function automatic logic [MAX_W-1:0] next_q(
      input mode_t            mode,
      input logic [MAX_W-1:0] q,
      input logic [MAX_W-1:0] d,
      input logic             sin_l,
      input logic             sin_r,
      input int unsigned      w
   );
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] top;
      logic [MAX_W-1:0] qm;
      logic [MAX_W-1:0] lsb_l;
      logic [MAX_W-1:0] lsb_rot;
      logic [MAX_W-1:0] r;
      mask    = {MAX_W{1'b1}} >> (MAX_W - w);
      top     = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
      qm      = q & mask;
      lsb_l   = {{(MAX_W-1){1'b0}}, sin_l};
      lsb_rot = {{(MAX_W-1){1'b0}}, |(qm & top)};
      case (mode)
         MODE_LOAD: r = d & mask;
         MODE_SHL:  r = ((qm << 1) | lsb_l) & mask;
         MODE_SHR:  r = (qm >> 1) | (sin_r ? top : {MAX_W{1'b0}});
         MODE_ROL:  r = ((qm << 1) | lsb_rot) & mask;
         MODE_ROR:  r = (qm >> 1) | (qm[0] ? top : {MAX_W{1'b0}});
         MODE_CLR:  r = {MAX_W{1'b0}};
         default:   r = qm;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shift_cnt.sv
// Shift counter: tracks shifts left for the loaded word and pulses done
// on the shift that takes the count from 1 to 0.
module shift_cnt #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic          shift,
   input  logic          clear,
   output logic [CW-1:0] cnt,
   output logic          done
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (!en) begin
         done <= 1'b0;
      end else if (clear) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (load) begin
         cnt  <= CW'(WIDTH);
         done <= 1'b0;
      end else if (shift) begin
         // Shifting at zero saturates instead of wrapping.
         if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         done <= (cnt == CW'(1));
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold/load/shift/rotate/clear with a bank enable
// and a shift counter that flags when a loaded word has been shifted out.
module shift_reg_univ
   import shift_reg_pkg::*;
#(
   parameter  int               WIDTH     = 8,
   parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   localparam int               CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   mode_t            m;
   logic [WIDTH-1:0] nq;
   logic             do_load;
   logic             do_shift;
   logic             do_clear;

   assign m = mode_t'(mode);
   assign nq = WIDTH'(next_q(m, MAX_W'(q), MAX_W'(d), sin_l, sin_r, WIDTH));

   always_comb begin
      do_load  = 1'b0;
      do_shift = 1'b0;
      do_clear = 1'b0;
      case (m)
         MODE_LOAD:                              do_load  = 1'b1;
         MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: do_shift = 1'b1;
         MODE_CLR:                               do_clear = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= nq;
      end
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

   shift_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .load  (do_load),
      .shift (do_shift),
      .clear (do_clear),
      .cnt   (cnt),
      .done  (done)
   );

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: an 8-bit instance (RESET_VAL=A5) and a
// 1-bit instance share the clock and reset.
module tb_shift_reg_univ;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] cnt;
  logic       done;

  logic       en1;
  logic [2:0] mode1;
  logic [0:0] d1;
  logic       sin_l1;
  logic       sin_r1;
  logic [0:0] q1;
  logic       sout_l1;
  logic       sout_r1;
  logic [0:0] cnt1;
  logic       done1;

  int n_cmp;
  int n_fail;

  logic [7:0] shl_q [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
  logic       shl_so [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
    .sout_r(sout_r), .cnt(cnt), .done(done)
  );

  shift_reg_univ #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .d(d1),
    .sin_l(sin_l1), .sin_r(sin_r1), .q(q1), .sout_l(sout_l1),
    .sout_r(sout_r1), .cnt(cnt1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; mode = 3'b001; d = 8'h3C;
    step();
    n_cmp++;
    if (q !== 8'h3C) begin n_fail++; $display("FAIL reset_preload q=%h exp=3c", q); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_async_q q=%h exp=a5", q); end
    n_cmp++;
    if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_async_cnt cnt=%0d exp=0", cnt); end
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_async_done done=%b exp=0", done); end
    #1 rst = 1'b0;
    en = 1'b0; mode = 3'b001; d = 8'hFF;
    step();
    step();
    n_cmp++;
    if (q !== 8'hA5 || cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_hold q=%h cnt=%0d exp=a5/0", q, cnt);
    end
  endtask

  task automatic test_load_shl();
    en = 1'b1; mode = 3'b001; d = 8'h81;
    step();
    n_cmp++;
    if (q !== 8'h81 || cnt !== 4'd8 || done !== 1'b0) begin
      n_fail++; $display("FAIL load q=%h cnt=%0d done=%b exp=81/8/0", q, cnt, done);
    end
    n_cmp++;
    if (sout_r !== 1'b1) begin n_fail++; $display("FAIL sout_r got=%b exp=1", sout_r); end
    mode = 3'b010; sin_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (sout_l !== shl_so[k]) begin
        n_fail++; $display("FAIL shl_sout_l[%0d] got=%b exp=%b", k, sout_l, shl_so[k]);
      end
      step();
      n_cmp++;
      if (q !== shl_q[k] || cnt !== 4'(7 - k) || done !== (k == 7)) begin
        n_fail++;
        $display("FAIL shl_step[%0d] q=%h cnt=%0d done=%b exp=%h/%0d/%b",
                 k, q, cnt, done, shl_q[k], 7 - k, (k == 7));
      end
    end
    mode = 3'b000;
    step();
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL shl_done_drop done=%b exp=0", done); end
  endtask

  task automatic test_rotate_en();
    en = 1'b1; mode = 3'b001; d = 8'h01;
    step();
    mode = 3'b101;
    step();
    n_cmp++;
    if (q !== 8'h80 || cnt !== 4'd7) begin
      n_fail++; $display("FAIL ror q=%h cnt=%0d exp=80/7", q, cnt);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (q !== 8'h80 || cnt !== 4'd7 || done !== 1'b0) begin
        n_fail++; $display("FAIL en_gate[%0d] q=%h cnt=%0d done=%b exp=80/7/0", k, q, cnt, done);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reload_sat();
    int pulses;
    en = 1'b1; mode = 3'b001; d = 8'hFF;
    step();
    mode = 3'b011; sin_r = 1'b0;
    for (int k = 0; k < 7; k++) step();
    n_cmp++;
    if (q !== 8'h01 || cnt !== 4'd1) begin
      n_fail++; $display("FAIL shr7 q=%h cnt=%0d exp=01/1", q, cnt);
    end
    mode = 3'b001; d = 8'h3C;
    step();
    n_cmp++;
    if (q !== 8'h3C || cnt !== 4'd8 || done !== 1'b0) begin
      n_fail++; $display("FAIL reload q=%h cnt=%0d done=%b exp=3c/8/0", q, cnt, done);
    end
    mode = 3'b010; sin_l = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done === 1'b1) pulses++;
      if (k == 7) begin
        n_cmp++;
        if (cnt !== 4'd0 || done !== 1'b1) begin
          n_fail++; $display("FAIL sat_8th cnt=%0d done=%b exp=0/1", cnt, done);
        end
      end
    end
    n_cmp++;
    if (cnt !== 4'd0 || q !== 8'h00) begin
      n_fail++; $display("FAIL sat_end q=%h cnt=%0d exp=00/0", q, cnt);
    end
    n_cmp++;
    if (pulses != 1) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_clear_rsvd();
    en = 1'b1; mode = 3'b001; d = 8'hA5;
    step();
    mode = 3'b100;
    for (int k = 0; k < 4; k++) step();
    n_cmp++;
    if (q !== 8'h5A || cnt !== 4'd4) begin
      n_fail++; $display("FAIL rol4 q=%h cnt=%0d exp=5a/4", q, cnt);
    end
    mode = 3'b110;
    step();
    n_cmp++;
    if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL clear q=%h cnt=%0d done=%b exp=00/0/0", q, cnt, done);
    end
    mode = 3'b111; d = 8'hFF;
    step();
    n_cmp++;
    if (q !== 8'h00 || cnt !== 4'd0) begin
      n_fail++; $display("FAIL rsvd q=%h cnt=%0d exp=00/0", q, cnt);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; mode = 3'b001; d = 8'hF0;
    step();
    mode = 3'b010; sin_l = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (q !== 8'h80 || cnt !== 4'd5) begin
      n_fail++; $display("FAIL mid_shift q=%h cnt=%0d exp=80/5", q, cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset q=%h cnt=%0d done=%b exp=a5/0/0", q, cnt, done);
    end
    #1 rst = 1'b0;
    mode = 3'b000;
    step();
    n_cmp++;
    if (done !== 1'b0 || cnt !== 4'd0 || q !== 8'hA5) begin
      n_fail++; $display("FAIL mid_after q=%h cnt=%0d done=%b exp=a5/0/0", q, cnt, done);
    end
  endtask

  task automatic test_width1();
    en = 1'b0;
    en1 = 1'b1; mode1 = 3'b001; d1 = 1'b1;
    step();
    n_cmp++;
    if (q1 !== 1'b1 || cnt1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL w1_load q=%b cnt=%b done=%b exp=1/1/0", q1, cnt1, done1);
    end
    mode1 = 3'b100;
    step();
    n_cmp++;
    if (q1 !== 1'b1 || cnt1 !== 1'b0 || done1 !== 1'b1) begin
      n_fail++; $display("FAIL w1_rol q=%b cnt=%b done=%b exp=1/0/1", q1, cnt1, done1);
    end
    mode1 = 3'b010; sin_l1 = 1'b0;
    step();
    n_cmp++;
    if (q1 !== 1'b0 || done1 !== 1'b0 || sout_l1 !== 1'b0) begin
      n_fail++; $display("FAIL w1_shl q=%b done=%b sout_l=%b exp=0/0/0", q1, done1, sout_l1);
    end
    mode1 = 3'b011; sin_r1 = 1'b1;
    step();
    n_cmp++;
    if (q1 !== 1'b1 || sout_r1 !== 1'b1) begin
      n_fail++; $display("FAIL w1_shr q=%b sout_r=%b exp=1/1", q1, sout_r1);
    end
    mode1 = 3'b101;
    step();
    n_cmp++;
    if (q1 !== 1'b1 || cnt1 !== 1'b0) begin
      n_fail++; $display("FAIL w1_ror q=%b cnt=%b exp=1/0", q1, cnt1);
    end
    en1 = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    en1 = 1'b0; mode1 = 3'b000; d1 = 1'b0; sin_l1 = 1'b0; sin_r1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if (q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0 || q1 !== 1'b0) begin
      n_fail++; $display("FAIL por q=%h cnt=%0d done=%b q1=%b exp=a5/0/0/0", q, cnt, done, q1);
    end
    test_reset();
    test_load_shl();
    test_rotate_en();
    test_reload_sat();
    test_clear_rsvd();
    test_reset_mid();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
